// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg
//  Shared definitions for the multi-cycle shifter and the main control unit:
//  operation encodings, sequencer FSM states and a small op-decode helper.
//  No ports (package).
package shift_sequencer_pkg;

  // Operation encodings, shared with the main control unit.
  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11   // reserved, executes as SRL
  } op_e;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  // True when the operation fills vacated positions with the sign bit.
  function automatic logic isArith(input logic [1:0] opCode);
    return (opCode == OP_SRA) ? 1'b1 : 1'b0;
  endfunction

  // True when the operation shifts towards the MSB.
  function automatic logic isLeft(input logic [1:0] opCode);
    return (opCode == OP_SLL) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// shift_stage
//  Combinational narrow shifter: moves 'operand' by 0..SHIFT_STEP positions.
//  Ports:
//   operand in  WIDTH  value to shift
//   op      in  2      SLL / SRL / SRA (reserved code behaves as SRL)
//   amt     in  AMT_W  positions to shift this step (0..SHIFT_STEP)
//   shifted out WIDTH  shifted value
module shift_stage
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 4
) (
  input  logic [WIDTH-1:0] operand,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] shifted
);

  // Select the shift direction and fill for this step.
  always_comb begin
    shifted = operand;
    if (isLeft(op)) begin
      shifted = operand << amt;
    end else if (isArith(op)) begin
      shifted = WIDTH'($signed(operand) >>> amt);
    end else begin
      shifted = operand >> amt;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer
//  Multi-cycle 32-bit shift controller (SLL/SRL/SRA) that shifts at most
//  SHIFT_STEP positions per cycle through a narrow shift_stage.
//  Ports:
//   clk    in  1      rising-edge clock
//   rst_n  in  1      asynchronous active-low reset
//   start  in  1      request, accepted only while ready=1
//   op     in  2      00=SLL 01=SRL 10=SRA 11=SRL
//   A      in  WIDTH  operand
//   B      in  WIDTH  unsigned shift amount, saturates at WIDTH
//   ready  out 1      high in IDLE
//   busy   out 1      high in SHIFT and DONE
//   done   out 1      one-cycle pulse in DONE
//   result out WIDTH  shifted value, valid from done until the next accept
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  // AW holds 0..WIDTH, SW holds 0..SHIFT_STEP.
  localparam int AW = $clog2(WIDTH) + 1;
  localparam int SW = $clog2(SHIFT_STEP) + 1;

  state_e           state_r;
  state_e           nextState_s;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] nextData_s;
  logic [AW-1:0]    rem_r;
  logic [AW-1:0]    nextRem_s;
  logic [1:0]       op_r;
  logic [1:0]       nextOp_s;
  logic [AW-1:0]    amt_s;
  logic [AW-1:0]    stepWide_s;
  logic [SW-1:0]    step_s;
  logic [AW-1:0]    remAfter_s;
  logic [WIDTH-1:0] stageOut_s;
  logic             ready_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;

  // Saturating amount: the full B register is compared, only the low bits are kept.
  always_comb begin
    amt_s = '0;
    if (B >= WIDTH) begin
      amt_s = AW'(WIDTH);
    end else begin
      amt_s = B[AW-1:0];
    end
  end

  // Per-cycle step is the smaller of the remaining amount and SHIFT_STEP.
  always_comb begin
    stepWide_s = rem_r;
    if (rem_r > AW'(SHIFT_STEP)) begin
      stepWide_s = AW'(SHIFT_STEP);
    end else begin
      stepWide_s = rem_r;
    end
    step_s     = stepWide_s[SW-1:0];
    remAfter_s = rem_r - stepWide_s;
  end

  shift_stage #(
    .WIDTH(WIDTH),
    .AMT_W(SW)
  ) uStage (
    .operand(data_r),
    .op     (op_r),
    .amt    (step_s),
    .shifted(stageOut_s)
  );

  // Next-state and next datapath values.
  always_comb begin
    nextState_s = state_r;
    nextData_s  = data_r;
    nextRem_s   = rem_r;
    nextOp_s    = op_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          nextData_s = A;
          nextOp_s   = op;
          nextRem_s  = amt_s;
          if (amt_s == '0) begin
            nextState_s = S_DONE;
          end else begin
            nextState_s = S_SHIFT;
          end
        end else begin
          nextState_s = S_IDLE;
        end
      end
      S_SHIFT: begin
        nextData_s = stageOut_s;
        nextRem_s  = remAfter_s;
        if (remAfter_s == '0) begin
          nextState_s = S_DONE;
        end else begin
          nextState_s = S_SHIFT;
        end
      end
      S_DONE: begin
        nextState_s = S_IDLE;
      end
      default: begin
        nextState_s = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Datapath registers: working value, remaining amount, latched op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= '0;
      rem_r  <= '0;
      op_r   <= 2'b00;
    end else begin
      data_r <= nextData_s;
      rem_r  <= nextRem_s;
      op_r   <= nextOp_s;
    end
  end

  // Registered status outputs; result is captured as the FSM enters DONE so it
  // is already valid while done is high, and then holds through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
    end else begin
      ready_r <= (nextState_s == S_IDLE);
      busy_r  <= (nextState_s == S_SHIFT) || (nextState_s == S_DONE);
      done_r  <= (nextState_s == S_DONE);
      if (nextState_s == S_DONE) begin
        result_r <= nextData_s;
      end
    end
  end

  assign ready  = ready_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer
//  Scoreboard bench: the stimulus process pushes the expected result and the
//  expected done cycle for each accepted operation; a monitor pops and compares
//  whenever done is seen.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          doneCyc;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [31:0] lastRes = 32'd0;

  shift_sequencer #(.WIDTH(32), .SHIFT_STEP(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: shift amount saturates at 32, after which SLL/SRL give zero and SRA all sign bits.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
    int unsigned amt;
    logic [31:0] r;
    amt = (b >= 32'd32) ? 32 : b;
    if (o == 2'b10) begin
      if (amt >= 32) r = {32{a[31]}};
      else r = 32'($signed(a) >>> amt);
    end else if (o == 2'b00) begin
      if (amt >= 32) r = 32'd0;
      else r = a << amt;
    end else begin
      if (amt >= 32) r = 32'd0;
      else r = a >> amt;
    end
    return r;
  endfunction

  function automatic int latency(input logic [31:0] b);
    int unsigned amt;
    amt = (b >= 32'd32) ? 32 : b;
    return 1 + int'((amt + 7) / 8);
  endfunction

  // Issue one operation; called and returns at a negedge. junk=1 drives a
  // second start with random operands in the cycle after accept.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o, input bit junk);
    int   n;
    exp_t e;
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check("ready_timeout", {31'd0, ready}, 32'd1);
    end else begin
      check("result_hold", result, lastRes);
      start = 1'b1;
      A = a;
      B = b;
      op = o;
      e.res = model(a, b, o);
      e.doneCyc = cyc + latency(b);
      q.push_back(e);
      lastRes = e.res;
      @(negedge clk);
      if (junk) begin
        start = 1'b1;
        A = $urandom;
        B = $urandom_range(0, 40);
        op = 2'($urandom_range(0, 3));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      start = 1'b0;
      A = $urandom;
      B = $urandom;
      op = 2'($urandom_range(0, 3));
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", result, e.res);
        check("done_cycle", 32'(cyc), 32'(e.doneCyc));
        check("busy_in_done", {31'd0, busy}, 32'd1);
      end
    end
  end

  initial begin
    int n;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'd1000000007, 32'd143, 2'b01, 1'b0);
    issue(32'hC4653607, 32'd32, 2'b10, 1'b0);
    issue(32'h000F4335, 32'd13, 2'b01, 1'b1);
    issue(32'hFFF0BEB5, 32'd7, 2'b10, 1'b1);
    issue(32'd1, 32'd0, 2'b00, 1'b1);
    issue(32'd1, 32'd31, 2'b00, 1'b1);
    issue(32'h80000001, 32'd9, 2'b11, 1'b0);
    issue(32'h80000000, 32'hFFFF_FFFF, 2'b10, 1'b0);
    issue(32'h12345678, 32'd8, 2'b00, 1'b0);

    // Reset in the middle of a SHIFT: outputs clear at once, no done follows.
    issue(32'hDEADBEEF, 32'd32, 2'b01, 1'b0);
    check("busy_before_rst", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, ready}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    q.delete();
    lastRes = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_ready", {31'd0, ready}, 32'd1);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] rb;
      if ($urandom_range(0, 7) == 0) rb = $urandom;
      else rb = $urandom_range(0, 40);
      issue($urandom, rb, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
